// File: rtl/mprj_io_ctrl.sv
// Per-pad GPIO control: serial config shadow chain, committed to an active bank on load.
// Optional readback of the shifted-out chain on ser_out when MPRJ_IO_CTRL_READBACK_EN is defined.
module mprj_io_ctrl #(
    parameter int unsigned      TOTAL_PADS = 38,
    parameter int unsigned      CFG_W      = 13,
    parameter logic [CFG_W-1:0] CFG_INIT   = 13'h1803
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ser_valid,
    input  logic                    ser_data,
    output logic                    ser_ready,
    input  logic                    ser_load,
    output logic                    ser_out,
    output logic                    load_done,
    output logic                    load_err,
    input  logic [TOTAL_PADS-1:0]   mgmt_out,
    input  logic [TOTAL_PADS-1:0]   user_out,
    input  logic [TOTAL_PADS-1:0]   user_oeb,
    output logic [TOTAL_PADS-1:0]   pad_out,
    output logic [TOTAL_PADS-1:0]   pad_oeb,
    output logic [TOTAL_PADS-1:0]   pad_inp_dis,
    output logic [TOTAL_PADS-1:0]   pad_holdover,
    output logic [TOTAL_PADS-1:0]   pad_ib_mode_sel,
    output logic [TOTAL_PADS-1:0]   pad_vtrip_sel,
    output logic [TOTAL_PADS-1:0]   pad_slow_sel,
    output logic [TOTAL_PADS-1:0]   pad_analog_en,
    output logic [TOTAL_PADS-1:0]   pad_analog_sel,
    output logic [TOTAL_PADS-1:0]   pad_analog_pol,
    output logic [3*TOTAL_PADS-1:0] pad_dm
);
    localparam int unsigned N     = TOTAL_PADS * CFG_W;
    localparam int unsigned CNT_W = $clog2(N + 2);

    localparam int unsigned B_MGMT_ENA = 12;
    localparam int unsigned B_OEB      = 11;
    localparam int unsigned B_HOLDOVER = 10;
    localparam int unsigned B_INP_DIS  = 9;
    localparam int unsigned B_IB_MODE  = 8;
    localparam int unsigned B_AN_EN    = 7;
    localparam int unsigned B_AN_SEL   = 6;
    localparam int unsigned B_AN_POL   = 5;
    localparam int unsigned B_SLOW     = 4;
    localparam int unsigned B_VTRIP    = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_APPLY = 2'd2;

    logic [1:0]       state, state_next;
    logic [N-1:0]     shadow, active;
    logic [CNT_W-1:0] cnt, cnt_inc, cnt_next;
    logic             accept, err_next, cnt_clr;

    assign accept   = ser_valid & ser_ready;
    // Saturate one past full so any overrun still reads as a mismatch.
    assign cnt_inc  = (cnt == CNT_W'(N + 1)) ? cnt : cnt + CNT_W'(1);
    assign cnt_next = accept ? cnt_inc : cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state; a same-cycle bit is counted before the load check.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            S_IDLE, S_SHIFT: begin
                if (ser_load) begin
                    if (cnt_next == CNT_W'(N)) begin
                        state_next = S_APPLY;
                    end else begin
                        err_next   = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = S_IDLE;
                    end
                end else if (accept) begin
                    state_next = S_SHIFT;
                end
            end
            S_APPLY: begin
                cnt_clr    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow    <= {TOTAL_PADS{CFG_INIT}};
            active    <= {TOTAL_PADS{CFG_INIT}};
            cnt       <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            ser_ready <= 1'b1;
        end else begin
            if (accept) shadow <= {shadow[N-2:0], ser_data};
            if (state == S_APPLY) active <= shadow;
            cnt       <= cnt_clr ? '0 : cnt_next;
            load_done <= (state == S_APPLY);
            load_err  <= err_next;
            ser_ready <= (state_next != S_APPLY);
        end
    end

`ifdef MPRJ_IO_CTRL_READBACK_EN
    // Bit falling off the chain end, so a full shift replays the previous stream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       ser_out <= 1'b0;
        else if (accept) ser_out <= shadow[N-1];
    end
`else
    assign ser_out = 1'b0;
`endif

    for (genvar p = 0; p < TOTAL_PADS; p++) begin : g_pad
        logic [CFG_W-1:0] cfg;
        assign cfg                = active[p*CFG_W +: CFG_W];
        assign pad_out[p]         = cfg[B_MGMT_ENA] ? mgmt_out[p] : user_out[p];
        assign pad_oeb[p]         = cfg[B_MGMT_ENA] ? cfg[B_OEB]  : user_oeb[p];
        assign pad_holdover[p]    = cfg[B_HOLDOVER];
        assign pad_inp_dis[p]     = cfg[B_INP_DIS];
        assign pad_ib_mode_sel[p] = cfg[B_IB_MODE];
        assign pad_analog_en[p]   = cfg[B_AN_EN];
        assign pad_analog_sel[p]  = cfg[B_AN_SEL];
        assign pad_analog_pol[p]  = cfg[B_AN_POL];
        assign pad_slow_sel[p]    = cfg[B_SLOW];
        assign pad_vtrip_sel[p]   = cfg[B_VTRIP];
        assign pad_dm[3*p +: 3]   = cfg[2:0];
    end
endmodule

// File: tb/tb_mprj_io_ctrl.sv
// Randomized bench for mprj_io_ctrl against a bit-queue model of the config chain.
module tb_mprj_io_ctrl;
    localparam int unsigned P = 38;
    localparam int unsigned W = 13;
    localparam int unsigned N = P * W;
    localparam logic [W-1:0] INIT = 13'h1803;
`ifdef MPRJ_IO_CTRL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, ser_valid, ser_data, ser_ready, ser_load, ser_out, load_done, load_err;
    logic [P-1:0]   mgmt_out, user_out, user_oeb, pad_out, pad_oeb, pad_inp_dis, pad_holdover;
    logic [P-1:0]   pad_ib_mode_sel, pad_vtrip_sel, pad_slow_sel, pad_analog_en;
    logic [P-1:0]   pad_analog_sel, pad_analog_pol;
    logic [3*P-1:0] pad_dm;

    mprj_io_ctrl dut (
        .clock(clock), .reset(reset), .ser_valid(ser_valid), .ser_data(ser_data),
        .ser_ready(ser_ready), .ser_load(ser_load), .ser_out(ser_out),
        .load_done(load_done), .load_err(load_err), .mgmt_out(mgmt_out),
        .user_out(user_out), .user_oeb(user_oeb), .pad_out(pad_out), .pad_oeb(pad_oeb),
        .pad_inp_dis(pad_inp_dis), .pad_holdover(pad_holdover),
        .pad_ib_mode_sel(pad_ib_mode_sel), .pad_vtrip_sel(pad_vtrip_sel),
        .pad_slow_sel(pad_slow_sel), .pad_analog_en(pad_analog_en),
        .pad_analog_sel(pad_analog_sel), .pad_analog_pol(pad_analog_pol), .pad_dm(pad_dm)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_cfg [P];
    logic [W-1:0] stim [P];
    bit hist[$];
    int model_cnt;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Chain contents as the last N accepted bits, oldest first.
    function automatic void model_reset();
        hist.delete();
        for (int p = P - 1; p >= 0; p--)
            for (int b = W - 1; b >= 0; b--) hist.push_back(INIT[b]);
        for (int p = 0; p < P; p++) exp_cfg[p] = INIT;
        model_cnt = 0;
    endfunction

    function automatic bit model_accept(input bit b);
        bit o;
        o = hist.pop_front();
        hist.push_back(b);
        model_cnt++;
        return o;
    endfunction

    function automatic void model_commit();
        for (int p = 0; p < P; p++)
            for (int b = 0; b < W; b++) exp_cfg[p][b] = hist[N - 1 - (p * W + b)];
    endfunction

    task automatic randomize_io();
        mgmt_out = P'({$urandom(), $urandom()});
        user_out = P'({$urandom(), $urandom()});
        user_oeb = P'({$urandom(), $urandom()});
    endtask

    task automatic check_pads(input string tag);
        logic [P-1:0] e_out, e_oeb, e_inp, e_hold, e_ib, e_vt, e_slow, e_aen, e_asel, e_apol;
        logic [3*P-1:0] e_dm;
        #1;
        for (int p = 0; p < P; p++) begin
            logic [W-1:0] c;
            c = exp_cfg[p];
            e_out[p]  = c[12] ? mgmt_out[p] : user_out[p];
            e_oeb[p]  = c[12] ? c[11] : user_oeb[p];
            e_hold[p] = c[10]; e_inp[p]  = c[9]; e_ib[p]   = c[8];
            e_aen[p]  = c[7];  e_asel[p] = c[6]; e_apol[p] = c[5];
            e_slow[p] = c[4];  e_vt[p]   = c[3];
            e_dm[3*p +: 3] = c[2:0];
        end
        check({tag, ".pad_out"}, pad_out, e_out);
        check({tag, ".pad_oeb"}, pad_oeb, e_oeb);
        check({tag, ".pad_dm"}, pad_dm, e_dm);
        check({tag, ".pad_misc"},
              {pad_inp_dis, pad_holdover, pad_ib_mode_sel, pad_analog_en, pad_analog_sel},
              {e_inp, e_hold, e_ib, e_aen, e_asel});
        check({tag, ".pad_misc2"}, {pad_analog_pol, pad_slow_sel, pad_vtrip_sel},
              {e_apol, e_slow, e_vt});
    endtask

    task automatic send_bit(input bit b);
        bit o;
        ser_valid = 1'b1;
        ser_data  = b;
        tick();
        ser_valid = 1'b0;
        o = model_accept(b);
        check("ser_out", ser_out, RB ? o : 1'b0);
        if ($urandom_range(0, 7) == 0) tick();
    endtask

    // Sends stim in chain order (pad P-1 bit 12 first), truncated or padded by extra.
    task automatic send_stream(input int extra);
        for (int i = 0; i < int'(N) + extra; i++) begin
            if (i < int'(N)) send_bit(stim[(N - 1 - i) / W][(N - 1 - i) % W]);
            else             send_bit(1'($urandom()));
        end
    endtask

    task automatic do_load(input bit with_bit, input bit b);
        bit ok, o;
        ok = (model_cnt + int'(with_bit)) == int'(N);
        ser_load = 1'b1;
        if (with_bit) begin
            ser_valid = 1'b1;
            ser_data  = b;
        end
        tick();
        ser_load  = 1'b0;
        ser_valid = 1'b0;
        if (with_bit) begin
            o = model_accept(b);
            check("ser_out_ld", ser_out, RB ? o : 1'b0);
        end
        model_cnt = 0;
        check("load_err", load_err, !ok);
        check("load_done_early", load_done, 1'b0);
        check("ser_ready_ld", ser_ready, ok ? 1'b0 : 1'b1);
        if (ok) begin
            // Traffic during the apply cycle must be ignored.
            ser_valid = 1'b1;
            ser_data  = 1'($urandom());
            ser_load  = 1'b1;
            tick();
            ser_valid = 1'b0;
            ser_load  = 1'b0;
            model_commit();
            check("load_done", load_done, 1'b1);
            check("load_err_ok", load_err, 1'b0);
            check("ser_ready_post", ser_ready, 1'b1);
        end
        tick();
        check("load_done_clr", load_done, 1'b0);
        check("load_err_clr", load_err, 1'b0);
    endtask

    task automatic rand_stim();
        for (int p = 0; p < P; p++) stim[p] = W'($urandom());
    endtask

    initial begin
        reset = 1'b1; ser_valid = 1'b0; ser_data = 1'b0; ser_load = 1'b0;
        mgmt_out = '0; user_out = '0; user_oeb = '0;
        model_reset();
        tick(); tick();
        reset = 1'b0;
        tick();
        randomize_io();
        check("rst.pad_oeb", pad_oeb, 38'h3F_FFFF_FFFF);
        check("rst.pad_dm", pad_dm, {P{3'b011}});
        check("rst.ser_ready", ser_ready, 1'b1);
        check("rst.flags", {load_done, load_err, ser_out}, 3'b000);
        check_pads("rst");

        // Pad 0 reconfigured to user-owned, dm=7.
        for (int p = 0; p < P; p++) stim[p] = INIT;
        stim[0] = 13'h0007;
        send_stream(0);
        do_load(1'b0, 1'b0);
        randomize_io();
        check_pads("pad0");
        check("pad0.oeb", pad_oeb[0], user_oeb[0]);
        check("pad0.dm", pad_dm[2:0], 3'b111);

        // Short, long and empty loads are rejected; bank holds.
        rand_stim();
        send_stream(-1);
        do_load(1'b0, 1'b0);
        check_pads("short");
        rand_stim();
        send_stream(1);
        do_load(1'b0, 1'b0);
        check_pads("long");
        do_load(1'b0, 1'b0);
        check_pads("empty");

        // Pad 5 user-owned, pad 6 mgmt-owned.
        rand_stim();
        stim[5][12] = 1'b0;
        stim[6][12] = 1'b1;
        send_stream(0);
        do_load(1'b0, 1'b0);
        randomize_io();
        user_out[5] = 1'b1; user_oeb[5] = 1'b0; mgmt_out[5] = 1'b0;
        check_pads("pad5");
        check("pad5.out_oeb", {pad_out[5], pad_oeb[5]}, 2'b10);
        check("pad6.out", pad_out[6], mgmt_out[6]);

        // Random streams; last bit arriving with the load strobe.
        for (int k = 0; k < 3; k++) begin
            rand_stim();
            if (k == 1) begin
                send_stream(-1);
                do_load(1'b1, stim[0][0]);
            end else begin
                send_stream(0);
                do_load(1'b0, 1'b0);
            end
            randomize_io();
            check_pads("rand");
        end

        // Reset mid-stream discards partial data.
        rand_stim();
        for (int i = 0; i < 200; i++) send_bit(stim[(N - 1 - i) / W][(N - 1 - i) % W]);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("midrst.ser_ready", ser_ready, 1'b1);
        check("midrst.flags", {load_done, load_err, ser_out}, 3'b000);
        check_pads("midrst");
        tick();
        reset = 1'b0;
        tick();
        do_load(1'b0, 1'b0);
        rand_stim();
        send_stream(0);
        do_load(1'b0, 1'b0);
        randomize_io();
        check_pads("postrst");

        // Second stream replays the first on ser_out when readback is built in.
        rand_stim();
        send_stream(0);
        do_load(1'b0, 1'b0);
        check_pads("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
